// File: rtl/game_pkg.sv
// Shared game-logic types and helpers for the cheese score controller.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      RESPAWN  = 3'd2,
      COOLDOWN = 3'd3,
      WIN      = 3'd4
   } cheese_state_t;

   localparam int CTR_W          = 8;
   localparam int DEFAULT_TARGET = 9;

   // Count up by one but never past lim; the display cannot show more.
   function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v,
                                                input logic [CTR_W-1:0] lim);
      return (v >= lim) ? lim : v + CTR_W'(1);
   endfunction

   // Count down by one, holding at zero instead of wrapping.
   function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] v);
      return (v == '0) ? '0 : v - CTR_W'(1);
   endfunction

endpackage

// File: rtl/cheese_score_ctrl_edge_detect.sv
// Rising-edge detector: one registered delay, rise = in & ~delayed.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic rise
);

   logic r_in_d;

   // Remember last cycle's level so a held level fires only once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_in_d <= 1'b0;
      else        r_in_d <= in;
   end

   assign rise = in & ~r_in_d;

endmodule

// File: rtl/cheese_score_ctrl.sv
// Cheese score controller: counts Jerry/cheese pickups up to TARGET,
// handshakes cheese respawn and enforces a post-respawn cooldown.
// Optional macro CHEESE_LOSS_EN: Tom catching Jerry removes one cheese.
module cheese_score_ctrl
   import game_pkg::*;
#(
   parameter int TARGET          = DEFAULT_TARGET,
   parameter int COOLDOWN_CYCLES = 16_250_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             collision,
   input  logic             tom_catch,
   input  logic             respawn_ack,
   output logic [CTR_W-1:0] cheese_ctr,
   output logic             respawn_req,
   output logic             collect_pulse,
   output logic             win
);

   localparam int               TMR_W    = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(COOLDOWN_CYCLES - 1);
   localparam logic [CTR_W-1:0] TARGET_C = CTR_W'(TARGET);

   cheese_state_t    r_state, w_state_nx;
   logic [CTR_W-1:0] r_ctr, w_ctr_nx, w_ctr_inc;
   logic [TMR_W-1:0] r_timer, w_timer_nx;
   logic             r_req, w_req_nx;
   logic             r_pulse, w_pulse_nx;
   logic             r_win, w_win_nx;
   logic             w_start_rise, w_coll_rise;

   edge_detect u_start_ed (.clk(clk), .rst_n(rst_n), .in(start),     .rise(w_start_rise));
   edge_detect u_coll_ed  (.clk(clk), .rst_n(rst_n), .in(collision), .rise(w_coll_rise));

`ifdef CHEESE_LOSS_EN
   logic w_catch_rise;
   edge_detect u_catch_ed (.clk(clk), .rst_n(rst_n), .in(tom_catch), .rise(w_catch_rise));
`else
   // Port kept for a stable interface; nothing consumes it in this build.
   logic w_unused_catch;
   assign w_unused_catch = tom_catch;
`endif

   assign w_ctr_inc = sat_inc(r_ctr, TARGET_C);

   // Next state and next register values; a start edge outranks everything.
   always_comb begin
      w_state_nx = r_state;
      w_ctr_nx   = r_ctr;
      w_req_nx   = r_req;
      w_pulse_nx = 1'b0;
      w_win_nx   = r_win;
      w_timer_nx = r_timer;
      if (w_start_rise && (r_state != IDLE)) begin
         w_state_nx = ARMED;
         w_ctr_nx   = '0;
         w_win_nx   = 1'b0;
         w_req_nx   = 1'b0;
         w_timer_nx = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start_rise) begin
                  w_state_nx = ARMED;
                  w_ctr_nx   = '0;
               end
            end
            ARMED: begin
               if (w_coll_rise) begin
                  w_ctr_nx   = w_ctr_inc;
                  w_pulse_nx = 1'b1;
                  if (w_ctr_inc == TARGET_C) begin
                     w_state_nx = WIN;
                     w_win_nx   = 1'b1;
                  end else begin
                     w_state_nx = RESPAWN;
                     w_req_nx   = 1'b1;
                  end
               end
`ifdef CHEESE_LOSS_EN
               else if (w_catch_rise) begin
                  w_ctr_nx = sat_dec(r_ctr);
               end
`endif
            end
            RESPAWN: begin
               if (respawn_ack) begin
                  w_state_nx = COOLDOWN;
                  w_req_nx   = 1'b0;
                  w_timer_nx = '0;
               end
            end
            COOLDOWN: begin
               if (r_timer == TMR_LAST) begin
                  w_state_nx = ARMED;
                  w_timer_nx = '0;
               end else begin
                  w_timer_nx = r_timer + TMR_W'(1);
               end
`ifdef CHEESE_LOSS_EN
               if (w_catch_rise) w_ctr_nx = sat_dec(r_ctr);
`endif
            end
            WIN: begin
               w_win_nx = 1'b1;
            end
            default: begin
               w_state_nx = IDLE;
            end
         endcase
      end
   end

   // State register plus all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ctr   <= '0;
         r_req   <= 1'b0;
         r_pulse <= 1'b0;
         r_win   <= 1'b0;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nx;
         r_ctr   <= w_ctr_nx;
         r_req   <= w_req_nx;
         r_pulse <= w_pulse_nx;
         r_win   <= w_win_nx;
         r_timer <= w_timer_nx;
      end
   end

   assign cheese_ctr    = r_ctr;
   assign respawn_req   = r_req;
   assign collect_pulse = r_pulse;
   assign win           = r_win;

endmodule

// File: tb/tb_cheese_score_ctrl.sv
// Directed bench for cheese_score_ctrl with a per-cycle expectation queue
// and a pickup-strobe scoreboard. Honours CHEESE_LOSS_EN when defined.
module tb_cheese_score_ctrl;

   localparam int TGT = 9;
   localparam int CD  = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       collision = 1'b0;
   logic       tom_catch = 1'b0;
   logic       respawn_ack = 1'b0;
   logic [7:0] cheese_ctr;
   logic       respawn_req;
   logic       collect_pulse;
   logic       win;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [7:0] ctr;
      logic       req;
      logic       pulse;
      logic       win;
   } obs_t;

   obs_t       obs;
   obs_t       exp_q[$];
   string      tag_q[$];
   logic [7:0] pulse_q[$];

   assign obs = {cheese_ctr, respawn_req, collect_pulse, win};

   always #5 clk = ~clk;

   cheese_score_ctrl #(.TARGET(TGT), .COOLDOWN_CYCLES(CD)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .collision(collision),
      .tom_catch(tom_catch),
      .respawn_ack(respawn_ack),
      .cheese_ctr(cheese_ctr),
      .respawn_req(respawn_req),
      .collect_pulse(collect_pulse),
      .win(win)
   );

   task automatic check(input string tag, input obs_t e);
      n_chk++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s: observed ctr=%0d req=%b pulse=%b win=%b, expected ctr=%0d req=%b pulse=%b win=%b",
                tag, obs.ctr, obs.req, obs.pulse, obs.win, e.ctr, e.req, e.pulse, e.win);
      end
   endtask

   // Drive one cycle of inputs, queue the outputs expected after the edge,
   // then advance and compare against the head of the queue.
   task automatic cyc(input string tag, input logic coll, input logic ack,
                      input logic st, input logic ct,
                      input logic [7:0] c, input logic r, input logic p, input logic w);
      obs_t  e;
      string t;
      collision   = coll;
      respawn_ack = ack;
      start       = st;
      tom_catch   = ct;
      exp_q.push_back({c, r, p, w});
      tag_q.push_back(tag);
      if (p) pulse_q.push_back(c);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, e);
   endtask

   // One pickup from ARMED; below the target also ack and sit out the cooldown.
   task automatic pickup(input logic [7:0] n);
      cyc($sformatf("pickup%0d", n), 1'b1, 1'b0, 1'b0, 1'b0, n, (n != TGT), 1'b1, (n == TGT));
      if (n != TGT) begin
         cyc($sformatf("ack%0d", n), 1'b0, 1'b1, 1'b0, 1'b0, n, 1'b0, 1'b0, 1'b0);
         for (int i = 0; i < CD; i++)
            cyc($sformatf("cd%0d_%0d", n, i), 1'b0, 1'b0, 1'b0, 1'b0, n, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Every pickup strobe must match a queued pickup and carry its count.
   always @(negedge clk) begin
      if (rst_n && collect_pulse === 1'b1) begin
         n_chk++;
         assert (pulse_q.size() > 0) else begin
            n_fail++;
            $error("FAIL pulse_unexpected: observed strobe with ctr=%0d, expected no strobe", cheese_ctr);
         end
         if (pulse_q.size() > 0) begin
            logic [7:0] e;
            e = pulse_q.pop_front();
            n_chk++;
            assert (cheese_ctr === e) else begin
               n_fail++;
               $error("FAIL pulse_ctr: observed %0d, expected %0d", cheese_ctr, e);
            end
         end
      end
   end

   initial begin
      #2;
      check("reset_async", '0);
      collision = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", '0);
      collision = 1'b0;
      rst_n     = 1'b1;

      cyc("idle",        1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc("idle_coll",   1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc("start",       1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc("start_hold",  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc("armed_ack",   1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Single pulse pickup, collision ignored while waiting for ack.
      cyc("p1_edge",     1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0);
      cyc("p1_req",      1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
      cyc("p1_resp_coll",1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
      cyc("p1_ack",      1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < CD - 1; i++)
         cyc("cd1",      1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
      cyc("cd1_last_coll",1'b1,1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
      cyc("armed_low",   1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);

      // Collision held three cycles counts once.
      cyc("p2_edge",     1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0);
      cyc("p2_hold_a",   1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
      cyc("p2_hold_b",   1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
      cyc("p2_ack",      1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < CD; i++)
         cyc("cd2",      (i == 2), 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);

      // First edge after exactly CD cooldown cycles counts.
      for (int n = 3; n <= TGT; n++) pickup(8'(n));
      cyc("win_hold",    1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0, 1'b1);
      cyc("win_coll",    1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0, 1'b1);
      cyc("win_ack",     1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0, 1'b1);
      cyc("win_catch",   1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1);

      // Restart from WIN, then restart from RESPAWN at count 5.
      cyc("restart_win", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc("restart_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      for (int n = 1; n <= 4; n++) pickup(8'(n));
      cyc("p5_edge",     1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b1, 1'b0);
      cyc("p5_req",      1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
      cyc("restart_resp",1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc("after_restart",1'b0,1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      pickup(8'd1);

`ifdef CHEESE_LOSS_EN
      pickup(8'd2);
      cyc("catch1",      1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
      cyc("catch1_rel",  1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
      cyc("catch2",      1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc("catch2_rel",  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc("catch3_floor",1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc("catch3_rel",  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      for (int n = 1; n <= 3; n++) pickup(8'(n));
      cyc("catch_coll",  1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0);
      cyc("resp_rel",    1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
      cyc("resp_catch",  1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
      cyc("ack4",        1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0);
      cyc("cd_catch",    1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
`else
      cyc("catch_nop",   1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
      cyc("catch_rel",   1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
      cyc("catch_nop2",  1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
`endif

      repeat (2) @(negedge clk);
      n_chk++;
      assert (pulse_q.size() == 0) else begin
         n_fail++;
         $error("FAIL pulse_missing: observed %0d pickups without strobe, expected 0", pulse_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
